// File: rtl/prbs8_checker_if.sv
// Serial stream and status bundle between the SISO chain output and the PRBS8 checker.
// The master side supplies the bit stream; the slave side reports lock and error status.
interface prbs8_checker_if #(
  parameter int ERR_W = 8
);
  logic             en;
  logic             din;
  logic             locked;
  logic             err_pulse;
  logic             period;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en,
    output din,
    input  locked,
    input  err_pulse,
    input  period,
    input  err_count
  );

  modport slave (
    input  en,
    input  din,
    output locked,
    output err_pulse,
    output period,
    output err_count
  );
endinterface

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 (x^8+x^6+x^5+x^4+1) receive checker with windowed loss-of-lock
// and a saturating error counter; all outputs are registered.
module prbs8_checker #(
  parameter int SYNC_LEN  = 16,
  parameter int LOSS_ERRS = 4,
  parameter int WINDOW    = 255,
  parameter int ERR_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  prbs8_checker_if.slave bus
);

  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [MW-1:0] SYNC_MAX = MW'(SYNC_LEN);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_MAX = EW'(LOSS_ERRS);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCK
  } state_t;

  state_t           state, state_n;
  logic [7:0]       h, h_n;
  logic [3:0]       fill, fill_n;
  logic [MW-1:0]    match_cnt, match_n;
  logic [WW-1:0]    win_cnt, win_n;
  logic [EW-1:0]    win_err, win_err_n;
  logic             locked_q, locked_n;
  logic             err_pulse_q, err_pulse_n;
  logic             period_q, period_n;
  logic [ERR_W-1:0] err_count_q, err_count_n;

  logic             p;
  logic             mismatch;
  logic [7:0]       h_shift;
  logic [7:0]       h_free;
  logic [EW-1:0]    win_err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      h           <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      period_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state       <= state_n;
      h           <= h_n;
      fill        <= fill_n;
      match_cnt   <= match_n;
      win_cnt     <= win_n;
      win_err     <= win_err_n;
      locked_q    <= locked_n;
      err_pulse_q <= err_pulse_n;
      period_q    <= period_n;
      err_count_q <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    h_n         = h;
    fill_n      = fill;
    match_n     = match_cnt;
    win_n       = win_cnt;
    win_err_n   = win_err;
    err_pulse_n = 1'b0;
    period_n    = 1'b0;
    err_count_n = err_count_q;

    p           = h[7] ^ h[5] ^ h[4] ^ h[3];
    mismatch    = (bus.din != p);
    h_shift     = {h[6:0], bus.din};
    h_free      = {h[6:0], p};
    win_err_inc = win_err + {{(EW-1){1'b0}}, mismatch};

    if (bus.en) begin
      case (state)
        HUNT: begin
          h_n = h_shift;
          if (fill != 4'd8) fill_n = fill + 4'd1;
          // An all-zero history would predict zeros forever, so keep filling until it is nonzero.
          if ((fill_n == 4'd8) && (h_shift != 8'h00)) begin
            state_n = VERIFY;
            match_n = '0;
          end
        end

        VERIFY: begin
          h_n = h_shift;
          if (!mismatch) begin
            match_n = match_cnt + 1'b1;
            if (match_n == SYNC_MAX) begin
              state_n   = LOCK;
              win_n     = '0;
              win_err_n = '0;
            end
          end else begin
            match_n = '0;
          end
          if (h_shift == 8'h00) begin
            state_n = HUNT;
            fill_n  = '0;
            match_n = '0;
          end
        end

        LOCK: begin
          // The predictor free-runs here so a single flipped bit cannot poison later predictions.
          h_n      = h_free;
          period_n = (h_free == 8'hFF);
          if (mismatch) begin
            err_pulse_n = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) err_count_n = err_count_q + 1'b1;
          end
          if (win_err_inc == LOSS_MAX) begin
            state_n   = HUNT;
            fill_n    = '0;
            match_n   = '0;
            win_n     = '0;
            win_err_n = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_n     = '0;
            win_err_n = '0;
          end else begin
            win_n     = win_cnt + 1'b1;
            win_err_n = win_err_inc;
          end
        end

        default: begin
          state_n = HUNT;
          fill_n  = '0;
          match_n = '0;
        end
      endcase
    end

    locked_n = (state_n == LOCK);
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.period    = period_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed self-checking bench for prbs8_checker: lock, error counting, windowed loss of lock,
// EN hold, reset and counter saturation (second instance with ERR_W=2).
module tb_prbs8_checker;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clk = ~clk;

  prbs8_checker_if #(.ERR_W(8)) bus_a ();
  prbs8_checker_if #(.ERR_W(2)) bus_b ();

  prbs8_checker #(.SYNC_LEN(16), .LOSS_ERRS(4), .WINDOW(255), .ERR_W(8)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  prbs8_checker #(.SYNC_LEN(16), .LOSS_ERRS(4), .WINDOW(255), .ERR_W(2)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] g;
  int         ep_seen;
  int         per_seen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic out_locked(input bit sel);
    return sel ? bus_b.locked : bus_a.locked;
  endfunction

  function automatic logic out_err_pulse(input bit sel);
    return sel ? bus_b.err_pulse : bus_a.err_pulse;
  endfunction

  function automatic logic out_period(input bit sel);
    return sel ? bus_b.period : bus_a.period;
  endfunction

  function automatic logic [31:0] out_err_count(input bit sel);
    return sel ? 32'(bus_b.err_count) : 32'(bus_a.err_count);
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic applyStimulus(input bit sel, input logic en_v, input logic din_v,
                               input logic rst_v);
    if (sel) begin
      bus_b.en  = en_v;
      bus_b.din = din_v;
      reset_b   = rst_v;
    end else begin
      bus_a.en  = en_v;
      bus_a.din = din_v;
      reset_a   = rst_v;
    end
    @(posedge clk);
    #1;
    if (out_err_pulse(sel)) ep_seen++;
    if (out_period(sel)) per_seen++;
  endtask

  task automatic sendBit(input bit sel, input logic flip);
    logic b;
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
    applyStimulus(sel, 1'b1, b ^ flip, 1'b0);
  endtask

  task automatic doReset(input bit sel);
    applyStimulus(sel, 1'b1, 1'b0, 1'b1);
    applyStimulus(sel, 1'b1, 1'b1, 1'b1);
    g = 8'h01;
  endtask

  task automatic lockUp(input bit sel, input string tag);
    for (int i = 0; i < 23; i++) sendBit(sel, 1'b0);
    checkOutput({tag, "_edge23_unlocked"}, 32'(out_locked(sel)), 32'd0);
    sendBit(sel, 1'b0);
    checkOutput({tag, "_edge24_locked"}, 32'(out_locked(sel)), 32'd1);
  endtask

  initial begin
    int last_p;
    int n_p;
    int flag_hits;

    bus_a.en  = 1'b0;
    bus_a.din = 1'b0;
    reset_a   = 1'b1;
    bus_b.en  = 1'b0;
    bus_b.din = 1'b0;
    reset_b   = 1'b1;
    ep_seen   = 0;
    per_seen  = 0;
    g         = 8'h01;

    // Clean stream: lock on edge 24, then PERIOD every 255 bits with no errors.
    doReset(0);
    checkOutput("rst_locked", 32'(bus_a.locked), 32'd0);
    checkOutput("rst_err_pulse", 32'(bus_a.err_pulse), 32'd0);
    checkOutput("rst_period", 32'(bus_a.period), 32'd0);
    checkOutput("rst_err_count", 32'(bus_a.err_count), 32'd0);
    lockUp(0, "t1");
    last_p  = -1;
    n_p     = 0;
    ep_seen = 0;
    for (int i = 1; i <= 600; i++) begin
      sendBit(0, 1'b0);
      if (bus_a.period) begin
        if (last_p >= 0) checkOutput("t1_period_gap", 32'(i - last_p), 32'd255);
        last_p = i;
        n_p++;
      end
    end
    checkOutput("t1_period_ge2", 32'(n_p >= 2), 32'd1);
    checkOutput("t1_no_err_pulse", 32'(ep_seen), 32'd0);
    checkOutput("t1_err_count", 32'(bus_a.err_count), 32'd0);
    checkOutput("t1_still_locked", 32'(bus_a.locked), 32'd1);

    // All-zero input never leaves HUNT; the seeded stream then locks 24 edges in.
    doReset(0);
    flag_hits = 0;
    ep_seen   = 0;
    per_seen  = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      if (bus_a.locked) flag_hits++;
    end
    checkOutput("t2_zero_locked", 32'(flag_hits), 32'd0);
    checkOutput("t2_zero_pulses", 32'(ep_seen + per_seen), 32'd0);
    g = 8'h01;
    lockUp(0, "t2");

    // Single flipped bit: one pulse, one count, lock kept.
    doReset(0);
    lockUp(0, "t3");
    for (int i = 0; i < 10; i++) sendBit(0, 1'b0);
    sendBit(0, 1'b1);
    checkOutput("t3_err_pulse", 32'(bus_a.err_pulse), 32'd1);
    checkOutput("t3_err_count", 32'(bus_a.err_count), 32'd1);
    checkOutput("t3_locked", 32'(bus_a.locked), 32'd1);
    ep_seen = 0;
    for (int i = 0; i < 20; i++) sendBit(0, 1'b0);
    checkOutput("t3_no_more_errs", 32'(ep_seen), 32'd0);
    checkOutput("t3_err_count_hold", 32'(bus_a.err_count), 32'd1);

    // Four errors inside one window drop lock on the 4th; relock keeps the count.
    doReset(0);
    lockUp(0, "t4a");
    for (int k = 1; k <= 20; k++) begin
      sendBit(0, (k % 5) == 0);
      if (k == 15) checkOutput("t4_locked_after3", 32'(bus_a.locked), 32'd1);
    end
    checkOutput("t4_unlocked_on4", 32'(bus_a.locked), 32'd0);
    checkOutput("t4_pulse_on4", 32'(bus_a.err_pulse), 32'd1);
    checkOutput("t4_err_count", 32'(bus_a.err_count), 32'd4);
    lockUp(0, "t4b");
    checkOutput("t4_err_count_kept", 32'(bus_a.err_count), 32'd4);

    // Three errors, window wrap at locked edge 255, three more: lock survives.
    doReset(0);
    lockUp(0, "t5");
    for (int k = 1; k <= 300; k++) begin
      sendBit(0, (k == 10) || (k == 20) || (k == 30) || (k == 260) || (k == 270) || (k == 280));
      if (k == 260) checkOutput("t5_locked_after_wrap_err", 32'(bus_a.locked), 32'd1);
    end
    checkOutput("t5_locked", 32'(bus_a.locked), 32'd1);
    checkOutput("t5_err_count", 32'(bus_a.err_count), 32'd6);

    // EN low holds everything; a later clean stream still lines up with the history.
    ep_seen   = 0;
    per_seen  = 0;
    flag_hits = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1'b0, 1'(i % 2), 1'b0);
      if (!bus_a.locked) flag_hits++;
    end
    checkOutput("t6_hold_pulses", 32'(ep_seen + per_seen), 32'd0);
    checkOutput("t6_hold_locked", 32'(flag_hits), 32'd0);
    checkOutput("t6_hold_err_count", 32'(bus_a.err_count), 32'd6);
    for (int i = 0; i < 20; i++) sendBit(0, 1'b0);
    checkOutput("t6_resume_no_err", 32'(ep_seen), 32'd0);
    checkOutput("t6_resume_err_count", 32'(bus_a.err_count), 32'd6);
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_rst_locked", 32'(bus_a.locked), 32'd0);
    checkOutput("t6_rst_err_count", 32'(bus_a.err_count), 32'd0);
    checkOutput("t6_rst_err_pulse", 32'(bus_a.err_pulse), 32'd0);
    g = 8'h01;
    lockUp(0, "t6");
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    // ERR_W=2 instance: the count saturates at 3 across a loss and relock.
    doReset(1);
    lockUp(1, "sat_a");
    for (int k = 1; k <= 20; k++) begin
      sendBit(1, (k % 5) == 0);
      if (k == 15) checkOutput("sat_count_after3", 32'(bus_b.err_count), 32'd3);
    end
    checkOutput("sat_count_after4", 32'(bus_b.err_count), 32'd3);
    checkOutput("sat_unlocked", 32'(bus_b.locked), 32'd0);
    lockUp(1, "sat_b");
    for (int i = 0; i < 5; i++) sendBit(1, 1'b0);
    sendBit(1, 1'b1);
    checkOutput("sat_pulse_5th", 32'(bus_b.err_pulse), 32'd1);
    checkOutput("sat_count_after5", 32'(bus_b.err_count), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
